// File: rtl/gsim_pkg.sv
// Shared constants, FSM state encoding and helpers for the gsim_host solver front end.
// Optional residual check is built only when GSIM_RESID_CHECK_EN is defined.
package gsim_pkg;

  localparam int N     = 16;
  localparam int B_W   = 16;
  localparam int X_W   = 32;
  localparam int ACC_W = 40;
  localparam int IDX_W = 4;

  // state    | meaning
  // ST_IDLE  | waiting for start, host may write b buffer
  // ST_SEND  | streaming b[0..15] to the solver
  // ST_WAIT  | waiting for first solver word, timeout counter runs
  // ST_RECV  | capturing remaining solver words in index order
  // ST_CHECK | one residual row per cycle (check build only)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef GSIM_RESID_CHECK_EN
    ST_RECV  = 3'd3,
    ST_CHECK = 3'd4
`else
    ST_RECV  = 3'd3
`endif
  } state_t;

  // Magnitude of a signed accumulator value.
  function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/gsim_resid.sv
// Combinational residual row: r = 20x_i - 13(x_i-1 + x_i+1) + 6(x_i-2 + x_i+2)
// - (x_i-3 + x_i+3) - (b_i << 16), missing neighbours taken as zero.
// Only instantiated when GSIM_RESID_CHECK_EN is defined.
module gsim_resid
  import gsim_pkg::*;
#(
  parameter logic [31:0] RESID_TOL = 32'd65536
) (
  input  logic [N*X_W-1:0] x_i,
  input  logic [B_W-1:0]   b_i,
  input  logic [IDX_W-1:0] row_i,
  output logic             exceed_o
);

  localparam logic signed [ACC_W-1:0] K20 = 40'sd20;
  localparam logic signed [ACC_W-1:0] K13 = 40'sd13;
  localparam logic signed [ACC_W-1:0] K6  = 40'sd6;

  // x padded with three zero entries on each side so edge rows need no special case
  logic signed [ACC_W-1:0] xe [0:N+5];
  logic signed [ACC_W-1:0] bsh;
  logic signed [ACC_W-1:0] resid;
  logic [4:0]              p;

  // Sign-extend every x into the padded window
  always_comb begin
    for (int j = 0; j < N + 6; j++) xe[j] = '0;
    for (int i = 0; i < N; i++)
      xe[i+3] = {{(ACC_W-X_W){x_i[i*X_W+X_W-1]}}, x_i[i*X_W +: X_W]};
  end

  // Evaluate the selected row and compare its magnitude against the limit
  always_comb begin
    p     = {1'b0, row_i};
    bsh   = {{(ACC_W-B_W-16){b_i[B_W-1]}}, b_i, 16'b0};
    resid = K20 * xe[p + 5'd3]
          - K13 * (xe[p + 5'd2] + xe[p + 5'd4])
          + K6  * (xe[p + 5'd1] + xe[p + 5'd5])
          - (xe[p] + xe[p + 5'd6])
          - bsh;
    exceed_o = abs_acc(resid) > {{(ACC_W-32){1'b0}}, RESID_TOL};
  end

endmodule

// File: rtl/gsim_host.sv
// Host-side sequencer for an external linear solver: loads b, streams it out,
// waits (with timeout) for x, buffers the result, optionally checks residuals.
// Macro GSIM_RESID_CHECK_EN enables the CHECK state and resid_err_o.
module gsim_host
  import gsim_pkg::*;
#(
  parameter int          TIMEOUT   = 4096,
  parameter logic [31:0] RESID_TOL = 32'd65536
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [15:0] wr_data_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        in_en_o,
  output logic [15:0] b_in_o,
  input  logic        out_valid_i,
  input  logic [31:0] x_out_i,
  input  logic [3:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        resid_err_o
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             rerr_q, rerr_d;

  logic [B_W-1:0]   b_q   [N];
  logic [X_W-1:0]   res_q [N];

  logic             cap_en;
  logic [IDX_W-1:0] cap_idx;

`ifdef GSIM_RESID_CHECK_EN
  logic [N*X_W-1:0] x_flat;
  logic             resid_hit;

  // Flatten the result buffer for the residual row evaluator
  always_comb begin
    x_flat = '0;
    for (int i = 0; i < N; i++) x_flat[i*X_W +: X_W] = res_q[i];
  end

  gsim_resid #(.RESID_TOL(RESID_TOL)) u_resid (
    .x_i      (x_flat),
    .b_i      (b_q[idx_q]),
    .row_i    (idx_q),
    .exceed_o (resid_hit)
  );
`else
  logic unused_tol;
  assign unused_tol = ^RESID_TOL;
`endif

  // State and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state and status flag logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    rerr_d  = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SEND;
          idx_d   = '0;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          rerr_d  = 1'b0;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(N - 1)) begin
          state_d = ST_WAIT;
          wcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (out_valid_i) begin
          state_d = ST_RECV;
          idx_d   = 4'd1;
        end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      ST_RECV: begin
        if (out_valid_i) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(N - 1)) begin
`ifdef GSIM_RESID_CHECK_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef GSIM_RESID_CHECK_EN
      ST_CHECK: begin
        idx_d = idx_q + 4'd1;
        if (resid_hit) rerr_d = 1'b1;
        if (idx_q == 4'(N - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and capture strobes decoded from the current state
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    in_en_o = (state_q == ST_SEND);
    b_in_o  = in_en_o ? b_q[idx_q] : '0;
    cap_en  = out_valid_i && ((state_q == ST_WAIT) || (state_q == ST_RECV));
    cap_idx = (state_q == ST_RECV) ? idx_q : '0;
  end

  // b buffer (host writes in IDLE only) and result buffer (solver captures)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if ((state_q == ST_IDLE) && wr_en_i) b_q[wr_addr_i] <= wr_data_i;
      if (cap_en) res_q[cap_idx] <= x_out_i;
    end
  end

  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign rd_data_o   = res_q[rd_addr_i];
  assign resid_err_o = rerr_q;

endmodule

// File: tb/tb_gsim_host.sv
// Directed bench for gsim_host: table-driven buffer loads/reads plus hand-written
// sequences for streaming, gaps, timeout, residual flag and mid-solve reset.
module tb_gsim_host;

  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy, done, timeout, in_en, resid_err;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  gsim_host #(.TIMEOUT(TMO), .RESID_TOL(32'd65536)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (timeout),
    .in_en_o     (in_en),
    .b_in_o      (b_in),
    .out_valid_i (out_valid),
    .x_out_i     (x_out),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .resid_err_o (resid_err)
  );

  typedef struct { logic [3:0] addr; logic [15:0] data; } wr_vec_t;
  typedef struct { logic [3:0] addr; logic [31:0] exp;  } rd_vec_t;

  wr_vec_t     wv [16];
  rd_vec_t     rv [16];
  logic [15:0] b_exp [16];
  logic [31:0] x_tx  [16];

  int checks = 0;
  int errors = 0;

`ifdef GSIM_RESID_CHECK_EN
  localparam int  CHK_LAT  = 16;
  localparam logic RERR_HIT = 1'b1;
`else
  localparam int  CHK_LAT  = 0;
  localparam logic RERR_HIT = 1'b0;
`endif

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected buffer contents: x[i] = (i+base)<<16, read in reverse address order
  task automatic fill_rv(input int base, input bit zero);
    for (int i = 0; i < 16; i++) begin
      rv[i].addr = 4'(15 - i);
      rv[i].exp  = zero ? 32'd0 : 32'((15 - i + base) << 16);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = rv[i].addr;
      #1;
      chk($sformatf("%s rd[%0d]", tag, rv[i].addr), rd_data, rv[i].exp);
    end
  endtask

  task automatic load_b();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = wv[i].addr; wr_data = wv[i].data;
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic with_wr, input logic [3:0] wa, input logic [15:0] wd);
    start = 1'b1; wr_en = with_wr; wr_addr = wa; wr_data = wd;
    step();
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s in_en[%0d]", tag, k), in_en, 1'b1);
      chk($sformatf("%s b_in[%0d]", tag, k), b_in, b_exp[k]);
      if (k == 0) begin
        chk({tag, " done cleared"}, done, 1'b0);
        chk({tag, " timeout cleared"}, timeout, 1'b0);
        chk({tag, " resid cleared"}, resid_err, 1'b0);
      end
      step();
    end
    chk({tag, " in_en low after"}, in_en, 1'b0);
    chk({tag, " b_in zero after"}, b_in, 16'd0);
    chk({tag, " busy in wait"}, busy, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    out_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_words(input bit gap);
    for (int i = 0; i < 16; i++) begin
      if (gap && i == 8) begin
        repeat (3) begin
          out_valid = 1'b0; x_out = 32'hDEADBEEF;
          step();
        end
      end
      out_valid = 1'b1; x_out = x_tx[i];
      step();
    end
    out_valid = 1'b0; x_out = 32'd0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " done latency"}, 40'(n), 40'(CHK_LAT));
    chk({tag, " timeout"}, timeout, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic set_x(input int base);
    for (int i = 0; i < 16; i++) x_tx[i] = 32'((i + base) << 16);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    out_valid = 1'b0; x_out = '0; rd_addr = '0;

    for (int i = 0; i < 16; i++) begin
      wv[i].addr = 4'(i);
      wv[i].data = 16'(i + 1);
    end

    // reset state
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst timeout", timeout, 1'b0);
    chk("rst in_en", in_en, 1'b0);
    chk("rst b_in", b_in, 16'd0);
    chk("rst resid", resid_err, 1'b0);
    fill_rv(0, 1'b1);
    check_results("rst");
    rst_n = 1'b1;
    step();

    // solve 1: b = 1..16, solver answers x = i<<16 after 3200 cycles
    load_b();
    for (int i = 0; i < 16; i++) b_exp[i] = 16'(i + 1);
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s1");
    idle_cycles(3200);
    chk("s1 still waiting", busy, 1'b1);
    chk("s1 no early timeout", timeout, 1'b0);
    set_x(0);
    send_words(1'b0);
    wait_done("s1");
    rd_addr = 4'd5; #1;
    chk("s1 rd5", rd_data, 32'h0005_0000);
    fill_rv(0, 1'b0);
    check_results("s1");

    // out_valid while IDLE must not touch the buffer
    step();
    out_valid = 1'b1; x_out = 32'h1234_5678;
    step();
    out_valid = 1'b0;
    chk("idle ov busy", busy, 1'b0);
    check_results("idle_ov");

    // solve 2: write and start in same cycle, stray start/write while busy, gap 7/8
    do_start(1'b1, 4'd0, 16'd50);
    b_exp[0] = 16'd50;
    check_stream("s2");
    step();
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'd999;
    step();
    start = 1'b0; wr_en = 1'b0;
    chk("s2 busy start ignored", in_en, 1'b0);
    idle_cycles(10);
    set_x(100);
    send_words(1'b1);
    wait_done("s2");
    fill_rv(100, 1'b0);
    check_results("s2");

    // solve 3: no solver response -> timeout after exactly TMO wait cycles
    step();
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s3");
    n = 1;
    while (busy && n < TMO + 100) begin
      step();
      if (busy) n++;
    end
    chk("s3 wait cycles", 40'(n), 40'(TMO));
    chk("s3 timeout", timeout, 1'b1);
    chk("s3 done", done, 1'b1);
    check_results("s3 kept");

    // solve 4: b all zero, one nonzero x -> residual flag in check build
    step();
    for (int i = 0; i < 16; i++) wv[i].data = 16'd0;
    load_b();
    for (int i = 0; i < 16; i++) b_exp[i] = 16'd0;
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s4");
    idle_cycles(20);
    for (int i = 0; i < 16; i++) x_tx[i] = 32'd0;
    x_tx[3] = 32'h0002_0000;
    send_words(1'b0);
    wait_done("s4");
    chk("s4 resid", resid_err, RERR_HIT);

    // solve 5: all zero -> no residual error
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s5");
    idle_cycles(20);
    x_tx[3] = 32'd0;
    send_words(1'b0);
    wait_done("s5");
    chk("s5 resid", resid_err, 1'b0);

    // solve 6: reset asserted while word 9 is presented
    for (int i = 0; i < 16; i++) wv[i].data = 16'(i + 7);
    load_b();
    for (int i = 0; i < 16; i++) b_exp[i] = 16'(i + 7);
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s6");
    idle_cycles(5);
    set_x(200);
    for (int i = 0; i < 9; i++) begin
      out_valid = 1'b1; x_out = x_tx[i];
      step();
    end
    out_valid = 1'b1; x_out = x_tx[9];
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst done", done, 1'b0);
    chk("mid rst timeout", timeout, 1'b0);
    chk("mid rst in_en", in_en, 1'b0);
    chk("mid rst b_in", b_in, 16'd0);
    chk("mid rst resid", resid_err, 1'b0);
    rd_addr = 4'd0; #1;
    chk("mid rst rd0", rd_data, 32'd0);
    out_valid = 1'b0; x_out = 32'd0;
    #1 rst_n = 1'b1;
    step();
    chk("post rst idle", busy, 1'b0);
    chk("post rst done", done, 1'b0);

    // solve 7: clean solve after reset, b buffer was cleared
    for (int i = 0; i < 16; i++) b_exp[i] = 16'd0;
    do_start(1'b0, 4'd0, 16'd0);
    check_stream("s7");
    idle_cycles(8);
    set_x(300);
    send_words(1'b0);
    wait_done("s7");
    fill_rv(300, 1'b0);
    check_results("s7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gsim_host.md
GSIM_HOST -- requirements
Module: gsim_host

Interface
REQ-001 Parameter TIMEOUT, default 4096: max cycles in WAIT before abort.
REQ-002 Parameter RESID_TOL, default 32'd65536 (1.0 in Q16.16): residual magnitude limit.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  host write strobe into b buffer.
REQ-006 wr_addr  input  4  b buffer index.
REQ-007 wr_data  input  16  signed b value.
REQ-008 start  input  1  launch one solve.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  result valid; high from completion until next accepted start.
REQ-011 timeout  output  1  last solve aborted in WAIT; cleared on accepted start.
REQ-012 in_en  output  1  to solver: b_in valid.
REQ-013 b_in  output  16  to solver: signed b value.
REQ-014 out_valid  input  1  from solver: x_out valid.
REQ-015 x_out  input  32  from solver: signed Q16.16 x value.
REQ-016 rd_addr  input  4  result buffer index.
REQ-017 rd_data  output  32  combinational result buffer read at rd_addr.
REQ-018 resid_err  output  1  some |residual| exceeded RESID_TOL (see Configuration).

Function
REQ-019 FSM states: IDLE, SEND, WAIT, RECV, CHECK; IDLE->SEND on start; SEND->WAIT after 16th word; WAIT->RECV on out_valid; RECV->CHECK (or IDLE if check compiled out) after 16th capture; CHECK->IDLE after 16 cycles.
REQ-020 wr_en accepted only in IDLE; ignored otherwise; wr_en and start in same IDLE cycle: write lands, solve uses new value.
REQ-021 start ignored when busy.
REQ-022 start sampled at cycle T: in_en high T+1..T+16 continuously, b_in = b[0]..b[15] in index order; in_en low and b_in = 0 otherwise.
REQ-023 WAIT: first cycle with out_valid high captures x_out into result[0] and enters RECV.
REQ-024 RECV: each cycle with out_valid high captures next index in order; out_valid low holds the index (no capture, no error).
REQ-025 out_valid in IDLE, SEND or CHECK ignored; result buffer unchanged.
REQ-026 WAIT lasting TIMEOUT cycles: timeout=1, done=1, return IDLE; result buffer keeps prior contents.
REQ-027 done rises the cycle after leaving RECV (check out) or CHECK (check in); done and timeout drop the cycle after accepted start.
REQ-028 Result buffer and b buffer persist across solves until overwritten.

Reset
REQ-029 reset low asynchronously: state IDLE, counters 0, both buffers 0, busy=0, done=0, timeout=0, in_en=0, b_in=0, resid_err=0.
REQ-030 reset mid-solve aborts immediately; no partial done.

Configuration
REQ-031 Macro GSIM_RESID_CHECK_EN defined: CHECK state computes per cycle i (0..15) r_i = 20x_i - 13(x_{i-1}+x_{i+1}) + 6(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) - (b_i<<16), out-of-range terms 0, in 40-bit signed arithmetic; resid_err set if any |r_i| > RESID_TOL, cleared on accepted start.
REQ-032 Macro undefined: no CHECK state, no residual logic, resid_err tied 0.

Structure
REQ-033 Shared package gsim_pkg holds N=16, B_W=16, X_W=32, ACC_W=40, FSM state enum.
REQ-034 Residual datapath in sub-module gsim_resid (combinational, one row per cycle), instantiated only under GSIM_RESID_CHECK_EN.

Verification
REQ-035 Load b[i]=i+1, start; in_en high exactly 16 cycles, b_in 1..16 from T+1.
REQ-036 Solver model returns x_out=i*65536 after 3200 cycles; rd_data(5)=0x00050000, done high, timeout 0.
REQ-037 out_valid low for 3 cycles between words 7 and 8; all 16 captured correctly, no duplicate.
REQ-038 No out_valid after stream; timeout=1, done=1 after exactly TIMEOUT WAIT cycles; buffer unchanged.
REQ-039 Check enabled, b all 0, x[3]=0x00020000 rest 0: resid_err=1; all x 0: resid_err=0.
REQ-040 reset low during RECV word 9: all outputs reset values next edge; next start runs full solve cleanly.
